// File: rtl/adc_channel_scheduler_pkg.sv
// Shared types and helpers for the ADC channel scheduler.
// Build option PRIORITY_CH0_EN (see adc_channel_scheduler.sv) does not affect this package.
package adc_sched_pkg;

  localparam int ADC_W_DEFAULT = 12;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } sched_state_e;

  // Channel-index width; a single channel still needs one bit.
  function automatic int ch_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adc_channel_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: nearest requester after ptr wins.
// With PRIORITY_CH0_EN defined, a pending req[0] overrides the rotation.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   idx,
  output logic              any
);

  logic [CH_W:0]       shift_amt;
  logic [2*NUM_CH-1:0] rot;
  int                  off;

  // Doubling req lets one shift express the wrap-around search from ptr+1.
  always_comb begin
    shift_amt = {1'b0, ptr} + (CH_W+1)'(1);
    rot       = {req, req} >> shift_amt;
    off       = 0;
    any       = 1'b0;
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      if (rot[j]) begin
        off = j;
        any = 1'b1;
      end
    end
    idx = CH_W'((int'(ptr) + 1 + off) % NUM_CH);
`ifdef PRIORITY_CH0_EN
    if (req[0]) begin
      idx = '0;
      any = 1'b1;
    end
`endif
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_onehot
      assign gnt[gi] = any && (idx == CH_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/adc_channel_scheduler.sv
// Shares one ADC among NUM_CH requesters: arbitrate, settle mux, convert, return tagged result.
// Define PRIORITY_CH0_EN to let channel 0 pre-empt the round-robin order.
module adc_channel_scheduler
  import adc_sched_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int ADC_W       = ADC_W_DEFAULT,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             req,
  output logic [NUM_CH-1:0]             gnt,
  output logic [ch_idx_w(NUM_CH)-1:0]   adc_ch_sel,
  output logic                          adc_start,
  input  logic                          adc_done,
  input  logic [ADC_W-1:0]              adc_data,
  output logic                          res_valid,
  output logic [ch_idx_w(NUM_CH)-1:0]   res_ch,
  output logic [ADC_W-1:0]              res_data,
  output logic                          timeout_err,
  output logic [ch_idx_w(NUM_CH)-1:0]   err_ch,
  input  logic                          err_clr
);

  localparam int CH_W    = ch_idx_w(NUM_CH);
  localparam int CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CH_W-1:0]  PTR_INIT     = CH_W'(NUM_CH - 1);

  sched_state_e      state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CH_W-1:0]   ptr_reg;

  logic [NUM_CH-1:0] arb_gnt;
  logic [CH_W-1:0]   arb_idx;
  logic              arb_any;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req (req),
    .ptr (ptr_reg),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // adc_ch_sel doubles as the registered winner for the whole conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      ptr_reg     <= PTR_INIT;
      gnt         <= '0;
      adc_ch_sel  <= '0;
      adc_start   <= 1'b0;
      res_valid   <= 1'b0;
      res_ch      <= '0;
      res_data    <= '0;
      timeout_err <= 1'b0;
      err_ch      <= '0;
    end else begin
      adc_start <= 1'b0;
      res_valid <= 1'b0;
      // A timeout set below overrides this clear.
      if (err_clr) timeout_err <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (arb_any) begin
            gnt        <= arb_gnt;
            adc_ch_sel <= arb_idx;
            cnt_reg    <= '0;
            state_reg  <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_reg == SETTLE_LAST) begin
            cnt_reg   <= '0;
            adc_start <= 1'b1;
            state_reg <= START;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        START: begin
          cnt_reg   <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          if (adc_done) begin
            res_valid <= 1'b1;
            res_data  <= adc_data;
            res_ch    <= adc_ch_sel;
            state_reg <= DONE;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            timeout_err <= 1'b1;
            err_ch      <= adc_ch_sel;
            state_reg   <= DONE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DONE: begin
          gnt       <= '0;
          state_reg <= IDLE;
`ifdef PRIORITY_CH0_EN
          if (adc_ch_sel != '0) ptr_reg <= adc_ch_sel;
`else
          ptr_reg <= adc_ch_sel;
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
